// File: rtl/spi_command_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer: FSM encoding, response
// status codes, the packed command word and small command helpers.
package spi_seq_pkg;

  localparam int unsigned MAX_XFER_BITS = 32;
  localparam int unsigned CMD_W         = 44;
  localparam int unsigned CNT_W         = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESPOND    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK            = 2'd0,
    RSP_START_TIMEOUT = 2'd1,
    RSP_ILLEGAL       = 2'd2
  } rsp_status_e;

  // One queued command as stored in the FIFO (44 bits).
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  write_bits;
    logic [5:0]  read_bits;
  } cmd_t;

  // A command the SPI master cannot execute: either field too long, the
  // combined frame too long, or nothing to do at all.
  function automatic logic cmd_is_illegal(input cmd_t c);
    logic [6:0] total;
    total = {1'b0, c.write_bits} + {1'b0, c.read_bits};
    return (c.write_bits > 6'(MAX_XFER_BITS)) ||
           (c.read_bits  > 6'(MAX_XFER_BITS)) ||
           (total        > 7'(MAX_XFER_BITS)) ||
           ((c.write_bits == 6'd0) && (c.read_bits == 6'd0));
  endfunction

  // Mask selecting the low read_bits bits of the SPI receive word.
  function automatic logic [31:0] read_mask(input logic [5:0] read_bits);
    logic [31:0] mask;
    if (read_bits >= 6'(MAX_XFER_BITS)) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << read_bits) - 32'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/spi_command_sequencer_if.sv
// Host command/response handshake plus the SPI master control signals.
// The master modport is the environment (host and SPI master), the slave
// modport is the sequencer itself.
interface spi_command_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [5:0]  cmd_write_bits;
  logic [5:0]  cmd_read_bits;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;

  logic [31:0] spi_data_out;
  logic [5:0]  spi_write_bits;
  logic [5:0]  spi_read_bits;
  logic        spi_request_action;
  logic        spi_busy;
  logic [31:0] spi_data_in;

  logic [4:0]  fifo_count;
  logic        idle;

  modport master (
    output cmd_valid, cmd_data, cmd_write_bits, cmd_read_bits,
    output rsp_ready, spi_busy, spi_data_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
    input  spi_data_out, spi_write_bits, spi_read_bits, spi_request_action,
    input  fifo_count, idle
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_write_bits, cmd_read_bits,
    input  rsp_ready, spi_busy, spi_data_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
    output spi_data_out, spi_write_bits, spi_read_bits, spi_request_action,
    output fifo_count, idle
  );

endinterface

// File: rtl/spi_command_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. DEPTH must be a power
// of two so the read/write pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [4:0]       count,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_q == 5'(DEPTH));
  assign empty     = (count_q == 5'd0);
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next pointer and occupancy values; a same-cycle push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset since the pointers restart.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/spi_command_sequencer.sv
// Queues host SPI commands, issues them one at a time to an SPI master and
// returns exactly one response per command in FIFO order.
module spi_command_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset,
  spi_command_sequencer_if.slave bus
);

  // Wide enough that the saturating counter can never stall below the limit.
  localparam int TMO_W = $clog2(START_TIMEOUT + 1) + 1;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    logic [TMO_W-1:0] r;
    if (v == {TMO_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + TMO_W'(1);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  rsp_status_e      rsp_status_q, rsp_status_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_q, req_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  cmd_t             cmd_in_s;
  cmd_t             head_s;
  logic [CMD_W-1:0] head_raw_s;
  logic [4:0]       fifo_count_s;
  logic             fifo_empty_s;
  logic             cmd_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             illegal_s;
  logic             timeout_s;

  assign cmd_in_s    = '{data: bus.cmd_data, write_bits: bus.cmd_write_bits,
                         read_bits: bus.cmd_read_bits};
  assign head_s      = cmd_t'(head_raw_s);
  assign cmd_ready_s = (fifo_count_s < 5'(DEPTH));
  assign push_s      = bus.cmd_valid && cmd_ready_s;
  assign pop_s       = (state_q == ST_IDLE) && !fifo_empty_s && !rsp_valid_q;
  assign illegal_s   = cmd_is_illegal(head_s);
  // True in the last WAIT_START cycle before START_TIMEOUT cycles have elapsed since the request.
  assign timeout_s   = ((32'(tmo_cnt_q) + 32'd1) >= 32'(START_TIMEOUT));

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (cmd_in_s),
    .pop   (pop_s),
    .rdata (head_raw_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; illegal commands skip the SPI master entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = illegal_s ? ST_RESPOND : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bus.spi_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_s) begin
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.spi_busy) begin
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RESPOND: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESPOND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: command capture, start timer, response formation and the request pulse.
  always_comb begin
    cmd_d        = cmd_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    tmo_cnt_d    = tmo_cnt_q;
    req_d        = (state_d == ST_ISSUE);
    rsp_valid_d  = (state_d == ST_RESPOND);
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          cmd_d     = head_s;
          tmo_cnt_d = '0;
          if (illegal_s) begin
            rsp_data_d   = 32'd0;
            rsp_status_d = RSP_ILLEGAL;
          end else begin
            rsp_status_d = rsp_status_q;
          end
        end else begin
          cmd_d = cmd_q;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = sat_inc(tmo_cnt_q);
      end
      ST_WAIT_START: begin
        if (bus.spi_busy) begin
          tmo_cnt_d = tmo_cnt_q;
        end else if (timeout_s) begin
          rsp_data_d   = 32'd0;
          rsp_status_d = RSP_START_TIMEOUT;
        end else begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.spi_busy) begin
          rsp_data_d   = bus.spi_data_in & read_mask(cmd_q.read_bits);
          rsp_status_d = RSP_OK;
        end else begin
          rsp_data_d = rsp_data_q;
        end
      end
      ST_RESPOND: begin
        rsp_data_d = rsp_data_q;
      end
      default: begin
        tmo_cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any in-flight command silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q        <= '0;
      rsp_data_q   <= 32'd0;
      rsp_status_q <= RSP_OK;
      rsp_valid_q  <= 1'b0;
      req_q        <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      cmd_q        <= cmd_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_valid_q  <= rsp_valid_d;
      req_q        <= req_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.cmd_ready          = cmd_ready_s;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_data           = rsp_data_q;
  assign bus.rsp_status         = rsp_status_q;
  assign bus.spi_data_out       = cmd_q.data;
  assign bus.spi_write_bits     = cmd_q.write_bits;
  assign bus.spi_read_bits      = cmd_q.read_bits;
  assign bus.spi_request_action = req_q;
  assign bus.fifo_count         = fifo_count_s;
  assign bus.idle               = fifo_empty_s && (state_q == ST_IDLE);

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Scoreboard bench for spi_command_sequencer: directed commands push their
// expected responses into a queue, a monitor checks every accepted response,
// and a behavioural SPI master model answers the request pulses.
module tb_spi_command_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_command_sequencer_if bus();

  spi_command_sequencer #(
    .DEPTH         (8),
    .START_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int cyc       = 0;
  int req_cnt   = 0;
  int req_cyc   = 0;
  int busy_left = 0;
  int busy_len  = 30;
  int skip_idx  = -1;

  logic [31:0] t4_d  [7] = '{32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0};
  logic [5:0]  t4_wb [7] = '{6'd30, 6'd0, 6'd33, 6'd0, 6'd32, 6'd32, 6'd0};
  logic [5:0]  t4_rb [7] = '{6'd8, 6'd0, 6'd0, 6'd33, 6'd1, 6'd0, 6'd32};
  logic [31:0] t4_ed [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
  logic [1:0]  t4_es [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};

  logic [31:0] t5_exp [9] = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hF, 32'h2F, 32'h6F, 32'hEF, 32'h1EF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // SPI master model: busy starts the cycle after a request and lasts busy_len cycles;
  // the request numbered skip_idx is ignored so the start timeout can expire.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      bus.spi_busy <= 1'b0;
      busy_left    <= 0;
    end else if (bus.spi_request_action) begin
      req_cnt <= req_cnt + 1;
      req_cyc <= cyc;
      if (req_cnt != skip_idx) begin
        bus.spi_busy <= 1'b1;
        busy_left    <= busy_len;
      end
    end else if (bus.spi_busy) begin
      if (busy_left <= 1) bus.spi_busy <= 1'b0;
      else busy_left <= busy_left - 1;
    end
  end

  // Response monitor: every accepted response must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: actual data 0x%08h status %0d, required no response",
                   bus.rsp_data, bus.rsp_status);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_status", {30'd0, bus.rsp_status}, {30'd0, e.status});
        end
      end
    end
  end

  task automatic push_cmd(input logic [31:0] d, input logic [5:0] wb, input logic [5:0] rb,
                          input logic want_rsp, input logic [31:0] ed, input logic [1:0] es,
                          output int pcyc);
    int n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    pcyc = cyc;
    if (!bus.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: cmd_ready actual 0, required 1");
    end else begin
      bus.cmd_valid      = 1'b1;
      bus.cmd_data       = d;
      bus.cmd_write_bits = wb;
      bus.cmd_read_bits  = rb;
      if (want_rsp) exp_q.push_back('{data: ed, status: es});
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    @(negedge clk);
    while (!bus.idle && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, bus.idle}, 32'd1);
  endtask

  task automatic wait_req(input int target, input int maxc);
    int n = 0;
    while (req_cnt < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("request_seen", 32'(req_cnt), 32'(target));
  endtask

  initial begin
    int pc;
    int pc2;
    int base;
    int r0;
    int n;
    bus.cmd_valid      = 1'b0;
    bus.cmd_data       = 32'd0;
    bus.cmd_write_bits = 6'd0;
    bus.cmd_read_bits  = 6'd0;
    bus.rsp_ready      = 1'b1;
    bus.spi_data_in    = 32'd0;
    reset              = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_status", {30'd0, bus.rsp_status}, 32'd0);
    check("rst_request", {31'd0, bus.spi_request_action}, 32'd0);
    check("rst_data_out", bus.spi_data_out, 32'd0);
    check("rst_write_bits", {26'd0, bus.spi_write_bits}, 32'd0);
    check("rst_read_bits", {26'd0, bus.spi_read_bits}, 32'd0);
    check("rst_fifo_count", {27'd0, bus.fifo_count}, 32'd0);
    check("rst_idle", {31'd0, bus.idle}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Write-only command, long transfer
    busy_len        = 30;
    bus.spi_data_in = 32'hDEAD_BEEF;
    base            = req_cnt;
    push_cmd(32'h00AB_1200, 6'd24, 6'd0, 1'b1, 32'h0, 2'd0, pc);
    wait_req(base + 1, 50);
    check("issue_latency", 32'(req_cyc - pc), 32'd2);
    repeat (10) @(negedge clk);
    check("held_data_out", bus.spi_data_out, 32'h00AB_1200);
    check("held_write_bits", {26'd0, bus.spi_write_bits}, 32'd24);
    check("held_read_bits", {26'd0, bus.spi_read_bits}, 32'd0);
    check("busy_not_idle", {31'd0, bus.idle}, 32'd0);
    wait_idle(100);
    check("t1_request_pulses", 32'(req_cnt - base), 32'd1);

    // Read command, masked receive data
    busy_len        = 5;
    bus.spi_data_in = 32'h1234_56A5;
    push_cmd(32'h8012_0000, 6'd16, 6'd8, 1'b1, 32'h0000_00A5, 2'd0, pc);
    wait_idle(100);

    // Start timeout, then the queued command still runs
    busy_len        = 4;
    base            = req_cnt;
    skip_idx        = base;
    bus.spi_data_in = 32'hFFFF_FFFF;
    push_cmd(32'h4000_0000, 6'd8, 6'd8, 1'b1, 32'h0, 2'd1, pc);
    push_cmd(32'h8100_0000, 6'd8, 6'd24, 1'b1, 32'h00FF_FFFF, 2'd0, pc2);
    wait_req(base + 1, 50);
    r0 = req_cyc;
    n  = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(cyc - r0), 32'd16);
    check("timeout_status", {30'd0, bus.rsp_status}, 32'd1);
    wait_req(base + 2, 50);
    wait_idle(100);

    // Illegal bit counts and legal 32-bit boundaries
    busy_len        = 3;
    base            = req_cnt;
    bus.spi_data_in = 32'hCAFE_F00D;
    for (int i = 0; i < 7; i++) begin
      push_cmd(t4_d[i], t4_wb[i], t4_rb[i], 1'b1, t4_ed[i], t4_es[i], pc);
    end
    wait_idle(300);
    check("illegal_no_request", 32'(req_cnt - base), 32'd2);

    // Back-pressure: fill the FIFO while the first response is held
    bus.rsp_ready   = 1'b0;
    bus.spi_data_in = 32'h89AB_CDEF;
    busy_len        = 3;
    for (int i = 0; i < 9; i++) begin
      push_cmd(32'h8000_0000 | 32'(i), 6'd8, 6'(i + 1), 1'b1, t5_exp[i], 2'd0, pc);
    end
    check("full_fifo_count", {27'd0, bus.fifo_count}, 32'd8);
    check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("held_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    check("held_rsp_data", bus.rsp_data, 32'h1);
    check("still_full", {27'd0, bus.fifo_count}, 32'd8);
    bus.rsp_ready = 1'b1;
    wait_idle(500);

    // Reset during WAIT_DONE with three commands queued
    busy_len = 50;
    base     = req_cnt;
    for (int i = 0; i < 4; i++) begin
      push_cmd(32'h0F00_0000 | 32'(i), 6'd8, 6'd8, 1'b0, 32'h0, 2'd0, pc);
    end
    repeat (10) @(negedge clk);
    check("queued_before_reset", {27'd0, bus.fifo_count}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle", {31'd0, bus.idle}, 32'd1);
    check("abort_fifo_count", {27'd0, bus.fifo_count}, 32'd0);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_new_request", 32'(req_cnt - base), 32'd1);

    // Normal operation resumes after the abort
    busy_len        = 2;
    bus.spi_data_in = 32'h1234_5678;
    push_cmd(32'h8055_0000, 6'd8, 6'd8, 1'b1, 32'h0000_0078, 2'd0, pc);
    wait_idle(100);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_command_sequencer.md
SPI_COMMAND_SEQUENCER -- requirements
Module: spi_command_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter START_TIMEOUT, default 16, max clk cycles from request to spi_busy high.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_data  input  32  MSB-first word to shift out (R/W bit, address, data).
REQ-008 cmd_write_bits  input  6  bits to write.
REQ-009 cmd_read_bits  input  6  bits to read.
REQ-010 rsp_valid  output  1  response held for host.
REQ-011 rsp_ready  input  1  host accepts response.
REQ-012 rsp_data  output  32  read data, right-justified.
REQ-013 rsp_status  output  2  0 OK, 1 START_TIMEOUT, 2 ILLEGAL.
REQ-014 spi_data_out  output  32  to SPI master data_out.
REQ-015 spi_write_bits, spi_read_bits  output  6 each  to SPI master.
REQ-016 spi_request_action  output  1  to SPI master request_action.
REQ-017 spi_busy  input  1  from SPI master busy.
REQ-018 spi_data_in  input  32  from SPI master data_in.
REQ-019 fifo_count  output  5  entries queued; idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-020 cmd_ready = (fifo_count < DEPTH); push on cmd_valid & cmd_ready; simultaneous push and pop when full is not possible, when non-full both occur same cycle with count unchanged.
REQ-021 FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND.
REQ-022 IDLE: if FIFO non-empty and rsp_valid low, pop head into command register, go ISSUE next cycle.
REQ-023 Popped command with write_bits>32, read_bits>32, write_bits+read_bits>32, or both zero: no SPI request, go RESPOND with rsp_status=2, rsp_data=0.
REQ-024 ISSUE: spi_request_action high exactly one cycle, then WAIT_START.
REQ-025 spi_data_out, spi_write_bits, spi_read_bits driven from command register, stable from ISSUE through exit of WAIT_DONE (SPI master compares bit counts during transfer).
REQ-026 WAIT_START: spi_busy high -> WAIT_DONE; START_TIMEOUT cycles elapsed without spi_busy -> RESPOND with status 1, rsp_data=0.
REQ-027 WAIT_DONE: on first cycle spi_busy low, capture spi_data_in masked to low read_bits bits (zero when read_bits=0) into rsp_data, status 0, go RESPOND.
REQ-028 WAIT_DONE has no timeout; transfer length is bounded by the SPI master.
REQ-029 RESPOND: rsp_valid high, rsp_data/rsp_status held until rsp_valid & rsp_ready; then IDLE same cycle rsp_valid drops.
REQ-030 Every popped command yields exactly one response, in FIFO order.
REQ-031 Latency: FIFO non-empty in IDLE -> spi_request_action high after exactly 2 cycles.
REQ-032 Counters: timeout counter reset on ISSUE entry; saturates, no wrap; FIFO pointers wrap modulo DEPTH.

Reset
REQ-033 On reset: FSM IDLE, FIFO empty, fifo_count=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0, spi_request_action=0, spi_data_out=0, spi_write_bits=0, spi_read_bits=0, idle=1.
REQ-034 Reset mid-transfer aborts silently: no response generated, in-flight and queued commands discarded; SPI master is reset by the same reset net.

Structure
REQ-035 Shared package spi_seq_pkg holds FSM state encoding, rsp_status codes, and 32-bit max-transfer constant.
REQ-036 Command FIFO is a separate sub-module sync_fifo (width 44, depth DEPTH, count output); all else in spi_command_sequencer.

Verification
REQ-037 Push write 0x00AB1200, wb=24, rb=0, SPI model busy 1 cycle after request for 30 cycles -> one request pulse, rsp_status=0, rsp_data=0.
REQ-038 Push read wb=16, rb=8, model returns data_in=0x123456A5 -> rsp_data=0x000000A5, status 0.
REQ-039 Model never asserts busy -> rsp_status=1 exactly 16 cycles after request, rsp_data=0, next command then issued.
REQ-040 Push wb=30, rb=8 -> no request pulse, rsp_status=2; push 9 commands with rsp_ready low -> cmd_ready low at fifo_count=8.
REQ-041 Assert reset during WAIT_DONE with 3 commands queued -> next cycle idle=1, fifo_count=0, rsp_valid=0, no response emitted.
